// File: rtl/mux2way16_pkg.sv
// Shared constants and types for the registered 2-way selector.
// Used by mux2way16_comb and mux2way16_sync.
package mux2way16_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/mux2way16_comb.sv
// Pure combinational 2-way selector: y = sel ? b : a.
module mux2way16_comb
    import mux2way16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // An unknown select must propagate as X rather than quietly pick a side.
    always_comb begin
        y = 'x;
        if (sel == SEL_B)
            y = b;
        else if (sel == SEL_A)
            y = a;
    end

endmodule

// File: rtl/mux2way16_sync.sv
// Registered 2-to-1 multiplexer with a one-cycle latency and a valid flag.
// Define MUX2WAY16_PARITY_EN to add the registered even-parity output out_par.
module mux2way16_sync
    import mux2way16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
`ifdef MUX2WAY16_PARITY_EN
    ,
    output logic             out_par
`endif
);

    logic [WIDTH-1:0] y;

    mux2way16_comb #(.WIDTH(WIDTH)) u_comb (
        .a   (a),
        .b   (b),
        .sel (sel),
        .y   (y)
    );

    // out holds its last result across idle cycles; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                out <= y;
        end
    end

`ifdef MUX2WAY16_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            out_par <= 1'b0;
        else if (in_valid)
            out_par <= ^y;
    end
`endif

endmodule

// File: tb/tb_mux2way16_sync.sv
// Self-checking bench for mux2way16_sync: vector table, hand sequences and a
// model-driven sweep, all checked through an expected-result queue.
module tb_mux2way16_sync;
    import mux2way16_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  sel = 1'b0;
    logic  in_valid = 1'b0;
    word_t a = '0;
    word_t b = '0;
    word_t out;
    logic  out_valid;
`ifdef MUX2WAY16_PARITY_EN
    logic  out_par;
`endif

    mux2way16_sync #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
`ifdef MUX2WAY16_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  r;
        logic  iv;
        logic  s;
        word_t av;
        word_t bv;
        word_t eout;
        logic  evld;
        logic  epar;
    } vec_t;

    typedef struct {
        string name;
        word_t out;
        logic  vld;
        logic  par;
    } exp_t;

    vec_t  tv[$];
    exp_t  sbq[$];
    int    n_chk = 0;
    int    n_fail = 0;
    word_t m_out = '0;
    logic  m_par = 1'b0;

    task automatic check();
        exp_t e;
        n_chk++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: no expected entry queued, out=%h", out);
            return;
        end
        e = sbq.pop_front();
        if (out !== e.out) begin
            n_fail++;
            $display("FAIL %s out: got %h expected %h", e.name, out, e.out);
        end
        n_chk++;
        if (out_valid !== e.vld) begin
            n_fail++;
            $display("FAIL %s out_valid: got %b expected %b", e.name, out_valid, e.vld);
        end
`ifdef MUX2WAY16_PARITY_EN
        n_chk++;
        if (out_par !== e.par) begin
            n_fail++;
            $display("FAIL %s out_par: got %b expected %b", e.name, out_par, e.par);
        end
`endif
    endtask

    // Drive one cycle of stimulus, queue its expected result, check after the edge.
    task automatic step(input string nm, input logic r, input logic iv, input logic s,
                        input word_t av, input word_t bv,
                        input word_t eo, input logic ev, input logic ep);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = iv; sel = s; a = av; b = bv;
        e.name = nm; e.out = eo; e.vld = ev; e.par = ep;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    // Reference behaviour used for the generated sequences.
    task automatic step_m(input string nm, input logic r, input logic iv, input logic s,
                          input word_t av, input word_t bv);
        logic v;
        v = 1'b0;
        if (r) begin
            m_out = '0;
            m_par = 1'b0;
        end else if (iv) begin
            m_out = s ? bv : av;
            m_par = ^m_out;
            v = 1'b1;
        end
        step(nm, r, iv, s, av, bv, m_out, v, m_par);
    endtask

    initial begin
        logic [4:0] b5;
        b5 = 5'd31;

        //              name        rst iv sel  a         b         out       vld par
        tv.push_back('{"reset0",    1, 1, 0, 16'h1234, 16'hABCD, 16'h0000, 0, 0});
        tv.push_back('{"reset1",    1, 1, 0, 16'h1234, 16'hABCD, 16'h0000, 0, 0});
        tv.push_back('{"first",     0, 1, 0, 16'h1234, 16'hABCD, 16'h1234, 1, 1});
        tv.push_back('{"sel_a",     0, 1, 0, 16'h0005, 16'h0003, 16'h0005, 1, 0});
        tv.push_back('{"sel_b",     0, 1, 1, 16'h0005, 16'h0003, 16'h0003, 1, 0});
        tv.push_back('{"hold",      0, 0, 0, 16'hFFFF, 16'h0003, 16'h0003, 0, 0});
        tv.push_back('{"narrow_b",  0, 1, 1, 16'h0000, 16'(b5),  16'h001F, 1, 1});
        tv.push_back('{"bound_a",   0, 1, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 1, 0});
        tv.push_back('{"bound_b",   0, 1, 1, 16'hFFFF, 16'h0000, 16'h0000, 1, 0});
        tv.push_back('{"bound_a2",  0, 1, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 1, 0});
        tv.push_back('{"par_a7",    0, 1, 0, 16'h0007, 16'h0000, 16'h0007, 1, 1});
        tv.push_back('{"par_b3",    0, 1, 1, 16'h0000, 16'h0003, 16'h0003, 1, 0});
        tv.push_back('{"hold_par",  0, 0, 0, 16'h0001, 16'h0001, 16'h0003, 0, 0});
        // Reset arriving mid-stream discards the in-flight operand.
        tv.push_back('{"pre_rst",   0, 1, 0, 16'hAAAA, 16'h0000, 16'hAAAA, 1, 0});
        tv.push_back('{"mid_rst",   1, 1, 0, 16'h5555, 16'h0000, 16'h0000, 0, 0});
        tv.push_back('{"post_idle", 0, 0, 1, 16'h5555, 16'h7777, 16'h0000, 0, 0});
        tv.push_back('{"resume",    0, 1, 1, 16'h5555, 16'hBEEF, 16'hBEEF, 1, 1});

        for (int i = 0; i < tv.size(); i++)
            step(tv[i].name, tv[i].r, tv[i].iv, tv[i].s, tv[i].av, tv[i].bv,
                 tv[i].eout, tv[i].evld, tv[i].epar);

        m_out = 16'hBEEF;
        m_par = 1'b1;

        for (int i = 0; i < 16; i++)
            step_m("sweep", 1'b0, 1'b1, i[0], word_t'(i), word_t'(16'h0100 + i));

        for (int i = 0; i < 40; i++)
            step_m("random", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                   1'($urandom), word_t'($urandom), word_t'($urandom));

        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard: %0d expected entries left unchecked", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
